// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit between data and stop.
module uart_tx_block #(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned CLKS_PER_BIT  = 10
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     tx_start,
  input  logic                     tx_abort,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  output logic                     serial_out,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]               state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [IDX_W-1:0]         idx, idx_next;
  logic [NUM_DATA_BITS-1:0] shift, shift_next;
  logic                     serial_next, busy_next, done_next;
  logic                     bit_end;
`ifdef UART_TX_PARITY_EN
  logic                     parity, parity_next;
`endif

  assign bit_end = (cnt == CNT_LAST);

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      shift      <= shift_next;
      serial_out <= serial_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
`ifdef UART_TX_PARITY_EN
      parity     <= parity_next;
`endif
    end
  end

  // Next-state and next-output logic; abort overrides everything
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    shift_next  = shift;
    serial_next = serial_out;
    busy_next   = tx_busy;
    done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif

    if (tx_abort) begin
      state_next  = ST_IDLE;
      cnt_next    = '0;
      idx_next    = '0;
      serial_next = 1'b1;
      busy_next   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_next = '0;
          idx_next = '0;
          if (tx_start) begin
            shift_next  = tx_data;
`ifdef UART_TX_PARITY_EN
            parity_next = ^tx_data;
`endif
            state_next  = ST_START;
            serial_next = 1'b0;
            busy_next   = 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt_next    = '0;
            state_next  = ST_DATA;
            serial_next = shift[0];
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_next = '0;
            if (idx == IDX_LAST) begin
              idx_next    = '0;
`ifdef UART_TX_PARITY_EN
              state_next  = ST_PARITY;
              serial_next = parity;
`else
              state_next  = ST_STOP;
              serial_next = 1'b1;
`endif
            end else begin
              // Bit 1 of the register becomes bit 0 after this shift
              idx_next    = idx + IDX_W'(1);
              shift_next  = shift >> 1;
              serial_next = shift[1];
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            cnt_next    = '0;
            state_next  = ST_STOP;
            serial_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next  = ST_IDLE;
          cnt_next    = '0;
          idx_next    = '0;
          serial_next = 1'b1;
          busy_next   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block: table of frames plus abort, reset and back-to-back sequences.
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_block;

  localparam int N = 8;
  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int F = N + 3;
`else
  localparam int F = N + 2;
`endif

  logic       clk;
  logic       n_rst;
  logic       tx_start;
  logic       tx_abort;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  int checks;
  int errors;

  uart_tx_block #(.NUM_DATA_BITS(N), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_abort   (tx_abort),
    .tx_data    (tx_data),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // line: frame bits in time order, leftmost = start bit, rightmost = stop bit
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
    logic       poke;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [9:0] line, input logic par, input int j);
`ifdef UART_TX_PARITY_EN
    if (j < N + 1) return line[9 - j];
    if (j == N + 1) return par;
    return 1'b1;
`else
    return line[9 - j];
`endif
  endfunction

  // Starts a frame (edge 0 is the first tick) and checks every mid-bit sample and the done pulse.
  task automatic run_frame(input vec_t v, input string nm);
    tx_data  = v.data;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    chk($sformatf("%s_busy_e0", nm), tx_busy, 1'b1);
    chk($sformatf("%s_line_e0", nm), serial_out, 1'b0);
    for (int c = 1; c <= F * C + 1; c++) begin
      tick();
      if ((c % C) == 5) begin
        chk($sformatf("%s_bit%0d", nm, c / C), serial_out, exp_bit(v.line, v.par, c / C));
        chk($sformatf("%s_busy%0d", nm, c / C), tx_busy, 1'b1);
      end
      if (c == F * C) begin
        chk($sformatf("%s_done", nm), tx_done, 1'b1);
        chk($sformatf("%s_busy_end", nm), tx_busy, 1'b0);
      end
      if (c == F * C - 1 || c == F * C + 1)
        chk($sformatf("%s_nodone%0d", nm, c), tx_done, 1'b0);
      if (v.poke && c == 25) begin
        tx_data  = ~v.data;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
    end
  endtask

  initial begin
    int dones;
    checks   = 0;
    errors   = 0;
    n_rst    = 1'b0;
    tx_start = 1'b0;
    tx_abort = 1'b0;
    tx_data  = 8'h00;

    vecs[0] = '{data: 8'hA5, line: 10'b0101001011, par: 1'b0, poke: 1'b0};
    vecs[1] = '{data: 8'h01, line: 10'b0100000001, par: 1'b1, poke: 1'b0};
    vecs[2] = '{data: 8'hFF, line: 10'b0111111111, par: 1'b0, poke: 1'b1};
    vecs[3] = '{data: 8'h00, line: 10'b0000000001, par: 1'b0, poke: 1'b0};
    vecs[4] = '{data: 8'h3C, line: 10'b0001111001, par: 1'b0, poke: 1'b1};
    vecs[5] = '{data: 8'h80, line: 10'b0000000011, par: 1'b1, poke: 1'b0};

    // Reset hold and idle after release
    tick();
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_line", serial_out, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
    end

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with tx_start held high; tx_data changes mid-frame
    dones    = 0;
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    tick();
    chk("b2b_line_e0", serial_out, 1'b0);
    for (int c = 1; c <= 2 * F * C + 5; c++) begin
      tick();
      if (tx_done) dones++;
      if (c < F * C && (c % C) == 5)
        chk($sformatf("b2b_f1_bit%0d", c / C), serial_out, exp_bit(vecs[4].line, 1'b0, c / C));
      if (c == F * C) chk("b2b_f1_done", tx_done, 1'b1);
      if (c > F * C && c < 2 * F * C && ((c - F * C) % C) == 5)
        chk($sformatf("b2b_f2_bit%0d", (c - F * C) / C), serial_out,
            exp_bit(vecs[4].line, 1'b0, (c - F * C) / C));
      if (c == 30)             tx_data  = 8'hC3;
      if (c == F * C - 5)      tx_data  = 8'h3C;
      if (c == F * C + 10)     tx_start = 1'b0;
      if (c == F * C + 20)     tx_data  = 8'h00;
    end
    chk("b2b_two_dones", (dones == 2), 1'b1);
    chk("b2b_idle_busy", tx_busy, 1'b0);

    // Abort at edge 45 of an 0xFF frame, new start at edge 50
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int c = 1; c <= 44; c++) tick();
    tx_abort = 1'b1;
    tick();
    tx_abort = 1'b0;
    chk("abort_line", serial_out, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_done", tx_done, 1'b0);
    for (int c = 46; c <= 49; c++) begin
      tick();
      chk("abort_nodone", tx_done, 1'b0);
      chk("abort_idle_line", serial_out, 1'b1);
    end
    run_frame(vecs[2], "after_abort");

    // Abort wins over a simultaneous start
    tx_data  = 8'h00;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int c = 1; c <= 12; c++) tick();
    tx_abort = 1'b1;
    tx_start = 1'b1;
    tick();
    tx_abort = 1'b0;
    tx_start = 1'b0;
    chk("abort_prio_busy", tx_busy, 1'b0);
    chk("abort_prio_line", serial_out, 1'b1);
    tick();
    chk("abort_prio_stay", tx_busy, 1'b0);

    // Asynchronous reset at edge 35 of a frame
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int c = 1; c <= 34; c++) tick();
    @(posedge clk);
    #1;
    chk("pre_rst_busy", tx_busy, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("async_rst_line", serial_out, 1'b1);
    chk("async_rst_busy", tx_busy, 1'b0);
    chk("async_rst_done", tx_done, 1'b0);
    tick();
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("post_rst_line", serial_out, 1'b1);
      chk("post_rst_busy", tx_busy, 1'b0);
      chk("post_rst_done", tx_done, 1'b0);
    end
    run_frame(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
